// File: rtl/run_sequencer.sv
// Run sequencer: turns the global run level into a clear / arm / run / drain
// sequence for the acquisition datapath, with run counting and drain-timeout status.
module run_sequencer #(
  parameter int RST_CYCLES    = 16,
  parameter int DRAIN_TIMEOUT = 1024,
  parameter int CNT_WIDTH     = 16
) (
  input  logic                 s_axi_aclk,
  input  logic                 s_axi_aresetn,
  input  logic                 run,
  input  logic                 dp_idle,
  input  logic                 dp_empty,
  output logic                 dp_clear,
  output logic                 dp_enable,
  output logic                 run_active,
  output logic                 drain_timeout,
  output logic [CNT_WIDTH-1:0] run_count,
  output logic [2:0]           state
);

  localparam int MAX_A = (RST_CYCLES > DRAIN_TIMEOUT) ? RST_CYCLES : DRAIN_TIMEOUT;
  localparam int MAX_C = (MAX_A > 2) ? MAX_A : 2;
  localparam int CW    = $clog2(MAX_C);

  localparam logic [CW-1:0] CLR_LAST = CW'(RST_CYCLES - 1);
  localparam logic [CW-1:0] DRN_LAST = CW'((DRAIN_TIMEOUT == 0) ? 0 : DRAIN_TIMEOUT - 1);
  localparam logic [CW-1:0] CYC_MAX  = '1;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_CLEAR = 3'd1,
    S_ARM   = 3'd2,
    S_RUN   = 3'd3,
    S_DRAIN = 3'd4,
    S_DONE  = 3'd5
  } state_t;

  state_t                state_q, state_d;
  logic [CW-1:0]         cyc_q;
  logic                  set_timeout;
  logic                  dp_clear_q, dp_enable_q, run_active_q, timeout_q;
  logic [CNT_WIDTH-1:0]  run_count_q;

  // Valid/ready is not used here: run, dp_idle and dp_empty are levels sampled
  // every clock, and every output is a level registered from the next state.
  always_comb begin
    state_d     = S_IDLE;
    set_timeout = 1'b0;
    case (state_q)
      S_IDLE:  state_d = run ? S_CLEAR : S_IDLE;
      S_CLEAR: begin
        if (cyc_q == CLR_LAST) state_d = run ? S_ARM : S_IDLE;
        else                   state_d = S_CLEAR;
      end
      S_ARM: begin
        if (!run)         state_d = S_IDLE;
        else if (dp_idle) state_d = S_RUN;
        else              state_d = S_ARM;
      end
      S_RUN:   state_d = run ? S_RUN : S_DRAIN;
      S_DRAIN: begin
        // A clean drain in the timeout cycle wins and does not raise the flag.
        if (dp_idle && dp_empty) begin
          state_d = S_DONE;
        end else if ((DRAIN_TIMEOUT != 0) && (cyc_q == DRN_LAST)) begin
          state_d     = S_DONE;
          set_timeout = 1'b1;
        end else begin
          state_d = S_DRAIN;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
    if (!s_axi_aresetn) begin
      state_q      <= S_IDLE;
      cyc_q        <= '0;
      dp_clear_q   <= 1'b0;
      dp_enable_q  <= 1'b0;
      run_active_q <= 1'b0;
      timeout_q    <= 1'b0;
      run_count_q  <= '0;
    end else begin
      state_q <= state_d;
      if (state_d != state_q)    cyc_q <= '0;
      else if (cyc_q != CYC_MAX) cyc_q <= cyc_q + 1'b1;

      // Outputs decoded from the next state so they line up with state_q.
      dp_clear_q   <= (state_d == S_CLEAR);
      dp_enable_q  <= (state_d == S_RUN);
      run_active_q <= (state_d != S_IDLE);

      if ((state_q == S_IDLE) && (state_d == S_CLEAR)) timeout_q <= 1'b0;
      else if (set_timeout)                            timeout_q <= 1'b1;

      if (state_q == S_DONE) run_count_q <= run_count_q + 1'b1;
    end
  end

  assign dp_clear      = dp_clear_q;
  assign dp_enable     = dp_enable_q;
  assign run_active    = run_active_q;
  assign drain_timeout = timeout_q;
  assign run_count     = run_count_q;
  assign state         = state_q;

endmodule

// File: tb/tb_run_sequencer.sv
// Randomized scoreboard bench for run_sequencer (RST_CYCLES=4, DRAIN_TIMEOUT=8,
// CNT_WIDTH=2): scenarios are expanded into per-cycle stimulus and expected outputs.
module tb_run_sequencer;

  localparam logic [2:0] ST_IDLE = 3'd0, ST_CLEAR = 3'd1, ST_ARM = 3'd2,
                         ST_RUN = 3'd3, ST_DRAIN = 3'd4, ST_DONE = 3'd5;

  logic       clk = 1'b0;
  logic       aresetn;
  logic       run, dp_idle, dp_empty;
  logic       dp_clear, dp_enable, run_active, drain_timeout;
  logic [1:0] run_count;
  logic [2:0] state;

  always #5 clk = ~clk;

  run_sequencer #(.RST_CYCLES(4), .DRAIN_TIMEOUT(8), .CNT_WIDTH(2)) dut (
    .s_axi_aclk    (clk),
    .s_axi_aresetn (aresetn),
    .run           (run),
    .dp_idle       (dp_idle),
    .dp_empty      (dp_empty),
    .dp_clear      (dp_clear),
    .dp_enable     (dp_enable),
    .run_active    (run_active),
    .drain_timeout (drain_timeout),
    .run_count     (run_count),
    .state         (state)
  );

  typedef struct {
    logic       rst_n;
    logic       r;
    logic       i;
    logic       e;
    logic [8:0] exp;
    string      tag;
  } stim_t;

  stim_t      stim_q[$];
  logic [8:0] exp_q[$];
  string      tag_q[$];

  int         n_tests = 0;
  int         n_fail  = 0;
  logic       m_dt    = 1'b0;
  logic [1:0] m_cnt   = 2'd0;

  // Expected output word {state, dp_clear, dp_enable, run_active, drain_timeout, run_count}.
  function automatic logic [8:0] mk(input logic [2:0] st, input logic dt, input logic [1:0] c);
    return {st, st == ST_CLEAR, st == ST_RUN, st != ST_IDLE, dt, c};
  endfunction

  function automatic logic rb();
    return 1'($urandom_range(0, 1));
  endfunction

  task automatic push(input logic rst_n, input logic r, input logic i, input logic e,
                      input logic [2:0] st, input string tag);
    stim_t s;
    s.rst_n = rst_n;
    s.r     = r;
    s.i     = i;
    s.e     = e;
    s.exp   = mk(st, m_dt, m_cnt);
    s.tag   = tag;
    stim_q.push_back(s);
  endtask

  task automatic not_both(output logic i, output logic e);
    int v;
    v = $urandom_range(0, 2);
    i = (v == 1);
    e = (v == 2);
  endtask

  // kind 0: abort during CLEAR, 1: abort during ARM, 2: full run.
  // a = ARM wait cycles, l = RUN cycles, w = DRAIN cycles before idle&empty.
  task automatic plan(input int kind, input int gap, input int a, input int l,
                      input int w, input bit b2b);
    logic i, e, rr;
    for (int g = 0; g < gap; g++) push(1, 0, rb(), rb(), ST_IDLE, "idle");
    m_dt = 1'b0;
    push(1, 1, rb(), rb(), ST_CLEAR, "clear");
    for (int k = 1; k < 4; k++) push(1, rb(), rb(), rb(), ST_CLEAR, "clear");
    if (kind == 0) begin
      push(1, 0, rb(), rb(), ST_IDLE, "clear_abort");
      return;
    end
    push(1, 1, rb(), rb(), ST_ARM, "arm");
    for (int k = 0; k < a; k++) push(1, 1, 0, rb(), ST_ARM, "arm_wait");
    if (kind == 1) begin
      push(1, 0, rb(), rb(), ST_IDLE, "arm_abort");
      return;
    end
    push(1, 1, 1, rb(), ST_RUN, "run");
    for (int k = 1; k < l; k++) push(1, 1, rb(), rb(), ST_RUN, "run");
    push(1, 0, rb(), rb(), ST_DRAIN, "drain");
    for (int j = 1; j <= 8; j++) begin
      rr = b2b ? 1'b1 : rb();
      if (j == w + 1) begin
        push(1, rr, 1, 1, ST_DONE, "done");
        break;
      end
      not_both(i, e);
      if (j == 8) begin
        m_dt = 1'b1;
        push(1, rr, i, e, ST_DONE, "done_timeout");
      end else begin
        push(1, rr, i, e, ST_DRAIN, "drain");
      end
    end
    m_cnt = m_cnt + 2'd1;
    push(1, b2b, rb(), rb(), ST_IDLE, "idle_after_done");
  endtask

  // Driver: applies one queued cycle per falling edge and hands its expectation on.
  initial begin
    stim_t s;
    aresetn  = 1'b0;
    run      = 1'b0;
    dp_idle  = 1'b0;
    dp_empty = 1'b0;
    forever begin
      @(negedge clk);
      if (stim_q.size() > 0) begin
        s        = stim_q.pop_front();
        run      = s.r;
        dp_idle  = s.i;
        dp_empty = s.e;
        exp_q.push_back(s.exp);
        tag_q.push_back(s.tag);
        aresetn  = s.rst_n;
      end
    end
  end

  // Monitor: checks after each rising edge, and right after an asynchronous reset.
  initial begin
    logic [8:0] got, exp;
    string      tag;
    forever begin
      @(posedge clk or negedge aresetn);
      #1;
      if (exp_q.size() > 0) begin
        exp = exp_q.pop_front();
        tag = tag_q.pop_front();
        got = {state, dp_clear, dp_enable, run_active, drain_timeout, run_count};
        n_tests++;
        if (got !== exp) begin
          n_fail++;
          $display("FAIL %s @%0t: got {st,clr,en,act,to,cnt}=%b_%b%b%b%b_%b, expected %b_%b%b%b%b_%b",
                   tag, $time, got[8:6], got[5], got[4], got[3], got[2], got[1:0],
                   exp[8:6], exp[5], exp[4], exp[3], exp[2], exp[1:0]);
        end
      end
    end
  end

  initial begin
    int  kind, gap;
    bit  b2b, prev_b2b;
    int  waited;

    // Reset held for five cycles with arbitrary inputs.
    for (int k = 0; k < 5; k++) push(0, (k == 4) ? 1'b0 : rb(), rb(), rb(), ST_IDLE, "reset");
    push(1, 0, rb(), rb(), ST_IDLE, "reset_release");

    plan(2, 2, 0, 15, 4, 0);   // nominal
    plan(2, 1, 0, 15, 9, 0);   // drain timeout
    push(1, 0, rb(), rb(), ST_IDLE, "timeout_sticky");
    plan(0, 1, 0, 1, 0, 0);    // single-cycle run pulse
    plan(2, 1, 2, 3, 7, 1);    // timeout and clean drain coincide; back-to-back next
    plan(2, 0, 1, 2, 2, 1);
    plan(2, 0, 0, 1, 0, 0);

    prev_b2b = 1'b0;
    for (int n = 0; n < 30; n++) begin
      kind = ($urandom_range(0, 9) < 2) ? $urandom_range(0, 1) : 2;
      gap  = prev_b2b ? 0 : $urandom_range(0, 3);
      b2b  = (kind == 2) && ($urandom_range(0, 2) == 0);
      plan(kind, gap, $urandom_range(0, 3), $urandom_range(1, 6), $urandom_range(0, 11), b2b);
      prev_b2b = b2b;
    end
    plan(2, 1, 1, 3, 3, 0);
    push(1, 0, rb(), rb(), ST_IDLE, "idle");

    // Bring the sequencer into RUN, then drop reset mid-cycle.
    m_dt = 1'b0;
    push(1, 1, rb(), rb(), ST_CLEAR, "clear");
    for (int k = 1; k < 4; k++) push(1, 1, rb(), rb(), ST_CLEAR, "clear");
    push(1, 1, 1, rb(), ST_ARM, "arm");
    push(1, 1, 1, rb(), ST_RUN, "run");
    push(1, 1, 1, rb(), ST_RUN, "run");
    m_cnt = 2'd0;
    push(0, 1, 1, 0, ST_IDLE, "async_reset");
    push(0, 0, rb(), rb(), ST_IDLE, "reset");
    push(1, 0, rb(), rb(), ST_IDLE, "reset_release");
    plan(2, 1, 0, 2, 1, 0);
    push(1, 0, rb(), rb(), ST_IDLE, "idle");

    waited = 0;
    while ((stim_q.size() > 0 || exp_q.size() > 0) && waited < 20000) begin
      @(posedge clk);
      waited++;
    end
    #2;
    if (stim_q.size() > 0 || exp_q.size() > 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL drain_wait: %0d entries left, required 0", stim_q.size() + exp_q.size());
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
